// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline-control definitions: hazard FSM encodings, interrupt
// sequence length and the load-use hazard predicate.
package hazard_ctrl_pkg;

    localparam int INT_SEQ_LEN = 4;
    localparam logic [2:0] INT_BASE = 3'd3;

    // Interrupt states are consecutive codes, so the last one is derived from the sequence length.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RET_W1    = 3'd1,
        RET_W2    = 3'd2,
        INT_FLUSH = INT_BASE,
        INT_PC    = INT_BASE + 3'd1,
        INT_FLG   = INT_BASE + 3'd2,
        INT_VEC   = INT_BASE + 3'(INT_SEQ_LEN - 1)
    } hz_state_t;

    function automatic logic load_use(
        input logic       rd_en_e,
        input logic       wr_en_e,
        input logic [1:0] rb_e,
        input logic [1:0] ra_d,
        input logic [1:0] rb_d,
        input logic       use_ra,
        input logic       use_rb
    );
        return rd_en_e & wr_en_e &
               ((use_ra & (ra_d == rb_e)) | (use_rb & (rb_d == rb_e)));
    endfunction

endpackage

// File: rtl/hazard_ctrl_intr_pending.sv
// Rising-edge detector on the interrupt line with a sticky pending flag that
// also remembers edges arriving while an interrupt is already being serviced.
module intr_pending (
    input  logic clk,
    input  logic reset,
    input  logic intr,
    input  logic service,
    input  logic clear,
    output logic pending
);

    logic intr_reg;
    logic pending_reg;
    logic queued_reg;
    logic rise;

    assign rise    = intr & ~intr_reg;
    assign pending = pending_reg;

    // An edge seen mid-service is parked in queued_reg so the vector-state clear cannot lose it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            intr_reg    <= 1'b0;
            pending_reg <= 1'b0;
            queued_reg  <= 1'b0;
        end else begin
            intr_reg <= intr;
            if (clear) begin
                pending_reg <= rise | queued_reg;
                queued_reg  <= 1'b0;
            end else begin
                pending_reg <= pending_reg | rise;
                queued_reg  <= queued_reg | (rise & service);
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch/return flushes and the
// multi-cycle interrupt entry sequence.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] RA_D,
    input  logic [1:0] RB_D,
    input  logic       use_ra_D,
    input  logic       use_rb_D,
    input  logic       rd_en_E,
    input  logic       wr_en_regf_E,
    input  logic [1:0] RB_E,
    input  logic       branch_taken_E,
    input  logic       is_ret_E,
    input  logic       intr,
    output logic       stall_F,
    output logic       stall_D,
    output logic       flush_D,
    output logic       flush_E,
    output logic       intr_push_pc,
    output logic       intr_push_flags,
    output logic       pc_sel_vec,
    output logic       intr_ack,
    output logic       busy
);

    hz_state_t state_reg;
    hz_state_t state_next;
    logic      pending;
    logic      hazard;
    logic      accept;
    logic      clear_pend;
    logic      service;

    assign hazard = load_use(rd_en_E, wr_en_regf_E, RB_E, RA_D, RB_D, use_ra_D, use_rb_D);

    intr_pending u_pending (
        .clk     (clk),
        .reset   (reset),
        .intr    (intr),
        .service (service),
        .clear   (clear_pend),
        .pending (pending)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        accept          = 1'b0;
        stall_F         = 1'b0;
        stall_D         = 1'b0;
        flush_D         = 1'b0;
        flush_E         = 1'b0;
        intr_push_pc    = 1'b0;
        intr_push_flags = 1'b0;
        pc_sel_vec      = 1'b0;
        intr_ack        = 1'b0;
        case (state_reg)
            IDLE: begin
                // Control transfers squash the bubble, so stall and flush of decode never coexist.
                if (branch_taken_E || is_ret_E) begin
                    flush_D = 1'b1;
                    flush_E = 1'b1;
                end else if (hazard) begin
                    stall_F = 1'b1;
                    stall_D = 1'b1;
                    flush_E = 1'b1;
                end
                if (is_ret_E) begin
                    state_next = RET_W1;
                end else if (pending && !branch_taken_E && !hazard) begin
                    accept     = 1'b1;
                    state_next = INT_FLUSH;
                end
            end
            RET_W1: begin
                flush_D    = 1'b1;
                flush_E    = 1'b1;
                state_next = RET_W2;
            end
            RET_W2: begin
                flush_D    = 1'b1;
                flush_E    = 1'b1;
                state_next = IDLE;
            end
            INT_FLUSH: begin
                stall_F    = 1'b1;
                flush_D    = 1'b1;
                flush_E    = 1'b1;
                state_next = INT_PC;
            end
            INT_PC: begin
                stall_F      = 1'b1;
                flush_D      = 1'b1;
                intr_push_pc = 1'b1;
                state_next   = INT_FLG;
            end
            INT_FLG: begin
                stall_F         = 1'b1;
                flush_D         = 1'b1;
                intr_push_flags = 1'b1;
                state_next      = INT_VEC;
            end
            INT_VEC: begin
                pc_sel_vec = 1'b1;
                intr_ack   = 1'b1;
                flush_D    = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // Outputs are combinational, so the asynchronous reset must also mask them directly.
        if (!reset) begin
            stall_F         = 1'b0;
            stall_D         = 1'b0;
            flush_D         = 1'b0;
            flush_E         = 1'b0;
            intr_push_pc    = 1'b0;
            intr_push_flags = 1'b0;
            pc_sel_vec      = 1'b0;
            intr_ack        = 1'b0;
        end
    end

    assign busy       = (state_reg != IDLE);
    assign clear_pend = (state_reg == INT_VEC);
    assign service    = accept || (state_reg == INT_FLUSH) ||
                        (state_reg == INT_PC) || (state_reg == INT_FLG);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: stimulus queues hand-computed output
// vectors, a negedge monitor pops and compares them against the ports.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] RA_D, RB_D, RB_E;
    logic       use_ra_D, use_rb_D, rd_en_E, wr_en_regf_E;
    logic       branch_taken_E, is_ret_E, intr;
    logic       stall_F, stall_D, flush_D, flush_E;
    logic       intr_push_pc, intr_push_flags, pc_sel_vec, intr_ack, busy;

    // Vector bit order: stall_F stall_D flush_D flush_E push_pc push_flags pc_sel_vec intr_ack busy
    localparam logic [8:0] SF  = 9'h100;
    localparam logic [8:0] SD  = 9'h080;
    localparam logic [8:0] FD  = 9'h040;
    localparam logic [8:0] FE  = 9'h020;
    localparam logic [8:0] PPC = 9'h010;
    localparam logic [8:0] PFL = 9'h008;
    localparam logic [8:0] VEC = 9'h004;
    localparam logic [8:0] ACK = 9'h002;
    localparam logic [8:0] BSY = 9'h001;
    localparam logic [8:0] NONE = 9'h000;

    logic [8:0] exp_q[$];
    string      name_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [8:0] mon_exp;
    string      mon_name;
    logic [8:0] obs;

    assign obs = {stall_F, stall_D, flush_D, flush_E, intr_push_pc,
                  intr_push_flags, pc_sel_vec, intr_ack, busy};

    hazard_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .RA_D            (RA_D),
        .RB_D            (RB_D),
        .use_ra_D        (use_ra_D),
        .use_rb_D        (use_rb_D),
        .rd_en_E         (rd_en_E),
        .wr_en_regf_E    (wr_en_regf_E),
        .RB_E            (RB_E),
        .branch_taken_E  (branch_taken_E),
        .is_ret_E        (is_ret_E),
        .intr            (intr),
        .stall_F         (stall_F),
        .stall_D         (stall_D),
        .flush_D         (flush_D),
        .flush_E         (flush_E),
        .intr_push_pc    (intr_push_pc),
        .intr_push_flags (intr_push_flags),
        .pc_sel_vec      (pc_sel_vec),
        .intr_ack        (intr_ack),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    // Monitor: every cycle with a queued expectation is compared on the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            checks++;
            if (obs !== mon_exp) begin
                errors++;
                $display("FAIL %s: outputs %b, expected %b", mon_name, obs, mon_exp);
            end else begin
                $display("ok   %s: outputs %b", mon_name, obs);
            end
        end
    end

    task automatic cyc(input logic [8:0] e, input string n);
        exp_q.push_back(e);
        name_q.push_back(n);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        RA_D = 2'd0; RB_D = 2'd0; RB_E = 2'd0;
        use_ra_D = 1'b0; use_rb_D = 1'b0;
        rd_en_E = 1'b0; wr_en_regf_E = 1'b0;
        branch_taken_E = 1'b0; is_ret_E = 1'b0;
    endtask

    task automatic load_use_on();
        RB_E = 2'd2; rd_en_E = 1'b1; wr_en_regf_E = 1'b1;
        RA_D = 2'd2; use_ra_D = 1'b1;
    endtask

    // Four interrupt-entry cycles; rise_at >= 0 pulses intr in that step, noisy drives hazards throughout.
    task automatic int_seq(input int rise_at, input bit noisy, input string tag);
        logic [8:0] e[4];
        e = '{SF | FD | FE | BSY, SF | FD | PPC | BSY, SF | FD | PFL | BSY, VEC | ACK | FD | BSY};
        if (noisy) begin
            load_use_on();
            branch_taken_E = 1'b1;
            is_ret_E = 1'b1;
        end
        for (int i = 0; i < 4; i++) begin
            if (rise_at >= 0) intr = (i == rise_at);
            cyc(e[i], $sformatf("%s_s%0d", tag, i));
        end
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        intr  = 1'b0;
        idle_inputs();
        @(posedge clk);
        #1;

        // Reset masks combinational outputs; first released cycle sees hazards.
        load_use_on();
        cyc(NONE, "rst_gate");
        reset = 1'b1;
        cyc(SF | SD | FE, "first_after_rst");
        idle_inputs();
        cyc(NONE, "idle");

        // Load-use detection and its qualifiers.
        load_use_on();
        cyc(SF | SD | FE, "lu_ra");
        idle_inputs();
        cyc(NONE, "lu_release");
        rd_en_E = 1'b1; wr_en_regf_E = 1'b1; RB_E = 2'd1; RB_D = 2'd1; use_rb_D = 1'b1;
        cyc(SF | SD | FE, "lu_rb");
        use_rb_D = 1'b0;
        cyc(NONE, "rb_unused");
        use_rb_D = 1'b1; rd_en_E = 1'b0;
        cyc(NONE, "not_load");
        rd_en_E = 1'b1; wr_en_regf_E = 1'b0;
        cyc(NONE, "no_write");
        idle_inputs(); load_use_on(); RA_D = 2'd3;
        cyc(NONE, "reg_mismatch");
        load_use_on(); branch_taken_E = 1'b1;
        cyc(FD | FE, "branch_over_lu");

        // Return: three flush cycles, inputs ignored in the wait states.
        idle_inputs(); is_ret_E = 1'b1;
        cyc(FD | FE, "ret_entry");
        is_ret_E = 1'b0; load_use_on();
        cyc(FD | FE | BSY, "ret_w1");
        branch_taken_E = 1'b1;
        cyc(FD | FE | BSY, "ret_w2");
        idle_inputs();
        cyc(NONE, "ret_done");

        // Interrupt with intr held high: exactly one sequence.
        intr = 1'b1;
        cyc(NONE, "int_edge");
        cyc(NONE, "int_accept");
        int_seq(-1, 1'b1, "int_a");
        cyc(NONE, "held_1");
        cyc(NONE, "held_2");
        cyc(NONE, "held_3");
        intr = 1'b0;
        cyc(NONE, "intr_low");

        // Second edge during INT_PC is serviced right after the first.
        intr = 1'b1;
        cyc(NONE, "q_edge");
        intr = 1'b0;
        cyc(NONE, "q_accept");
        int_seq(1, 1'b0, "q_first");
        cyc(NONE, "q_reaccept");
        int_seq(-1, 1'b0, "q_second");
        cyc(NONE, "q_done");

        // Edge coincident with the INT_VEC clear wins.
        intr = 1'b1;
        cyc(NONE, "v_edge");
        intr = 1'b0;
        cyc(NONE, "v_accept");
        int_seq(3, 1'b0, "v_first");
        intr = 1'b0;
        cyc(NONE, "v_reaccept");
        int_seq(-1, 1'b0, "v_second");
        cyc(NONE, "v_done");

        // Hazards in IDLE hold off acceptance.
        intr = 1'b1;
        cyc(NONE, "d_edge");
        intr = 1'b0; load_use_on();
        cyc(SF | SD | FE, "d_lu_blocks");
        idle_inputs(); branch_taken_E = 1'b1;
        cyc(FD | FE, "d_br_blocks");
        branch_taken_E = 1'b0;
        cyc(NONE, "d_accept");
        int_seq(-1, 1'b0, "d");
        cyc(NONE, "d_done");

        // Reset during INT_FLG with another edge already queued.
        intr = 1'b1;
        cyc(NONE, "r_edge");
        intr = 1'b0;
        cyc(NONE, "r_accept");
        cyc(SF | FD | FE | BSY, "r_flush");
        intr = 1'b1;
        cyc(SF | FD | PPC | BSY, "r_pc");
        intr = 1'b0; reset = 1'b0;
        cyc(NONE, "r_reset_flg");
        cyc(NONE, "r_reset_hold");
        reset = 1'b1;
        for (int i = 0; i < 6; i++) cyc(NONE, $sformatf("r_no_ack_%0d", i));

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
